// File: rtl/regfile_wr_arb_if.sv
// Write-request bundle between N_REQ requesters and the arbiter, plus the
// registered register-file write port the arbiter drives.
interface regfile_wr_arb_if #(
  parameter int WIDTH = 32,
  parameter int N_REG = 32,
  parameter int N_REQ = 4
);
  localparam int AW = $clog2(N_REG);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_lock;
  logic [N_REQ-1:0][AW-1:0]  req_addr;
  logic [N_REQ-1:0][WIDTH-1:0] req_data;
  logic [N_REQ-1:0]          req_ready;
  logic                      wen;
  logic [AW-1:0]             waddr;
  logic [WIDTH-1:0]          wdata;
  logic [IW-1:0]             wgnt_id;

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, wen, waddr, wdata, wgnt_id
  );

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, wen, waddr, wdata, wgnt_id
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin write arbiter with locked bursts in front of a single
// register-file write port; the accepted beat is registered onto wen/waddr/wdata.
module regfile_wr_arb #(
  parameter int WIDTH     = 32,
  parameter int N_REG     = 32,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  regfile_wr_arb_if.slave    bus
);
  localparam int AW = $clog2(N_REG);
  localparam int IW = $clog2(N_REQ);
  localparam logic [IW:0]   NREQ_W = (IW+1)'(N_REQ);
  localparam logic [IW-1:0] LAST   = IW'(N_REQ - 1);
  localparam logic [7:0]    MAXB   = 8'(MAX_BURST);
  localparam bit            MULTI  = (MAX_BURST > 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             wen_q;
  logic [AW-1:0]    waddr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [IW-1:0]    wgnt_id_q;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gnt_id;
  logic [IW-1:0]    win;
  logic             any_valid;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [IW:0] sum;
    sum       = '0;
    win       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!any_valid && bus.req_valid[sum[IW-1:0]]) begin
        any_valid = 1'b1;
        win       = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    grant   = '0;
    gnt_id  = win;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (rst_n && !hold) begin
      case (state_q)
        ARB: begin
          if (any_valid) begin
            grant[win] = 1'b1;
            if (bus.req_lock[win] && MULTI) begin
              state_d = BURST;
              owner_d = win;
              cnt_d   = 8'd1;
            end else begin
              ptr_d = inc_mod(win);
            end
          end
        end
        BURST: begin
          gnt_id = owner_q;
          if (bus.req_valid[owner_q]) begin
            grant[owner_q] = 1'b1;
            cnt_d = cnt_q + 8'd1;
            if (!bus.req_lock[owner_q] || (cnt_q + 8'd1 == MAXB)) begin
              state_d = ARB;
              ptr_d   = inc_mod(owner_q);
            end
          end else begin
            // Owner stalled: give up the lock rather than idle the port.
            state_d = ARB;
            ptr_d   = inc_mod(owner_q);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wgnt_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wen_q   <= |grant;
      if (|grant) begin
        waddr_q   <= bus.req_addr[gnt_id];
        wdata_q   <= bus.req_data[gnt_id];
        wgnt_id_q <= gnt_id;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.wen       = wen_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.wgnt_id   = wgnt_id_q;
endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench: each step drives requests and a hand-computed grant vector;
// granted beats go to a scoreboard that a separate write-port monitor drains.
module tb_regfile_wr_arb;
  localparam int WIDTH = 32;
  localparam int N_REG = 32;
  localparam int N_REQ = 4;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;
  logic hold;

  regfile_wr_arb_if #(.WIDTH(WIDTH), .N_REG(N_REG), .N_REQ(N_REQ)) bus ();

  regfile_wr_arb #(
    .WIDTH(WIDTH), .N_REG(N_REG), .N_REQ(N_REQ), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem [N_REG];
  int          n_checks = 0;
  int          n_fail = 0;
  int          step = 0;

  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic h,
                     input logic r, input logic [3:0] exp, input logic ovr,
                     input logic [4:0] oa, input logic [31:0] od);
    beat_t b;
    @(negedge clk);
    rst_n = r;
    hold = h;
    bus.req_valid = v;
    bus.req_lock = l;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_addr[i] = ovr ? oa : 5'(step + i);
      bus.req_data[i] = ovr ? od : {16'(step), 16'(i)};
    end
    #1;
    n_checks++;
    if (bus.req_ready !== exp) begin
      n_fail++;
      $display("FAIL ready step=%0d got=%b exp=%b", step, bus.req_ready, exp);
    end
    if (exp != 4'b0) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (exp[i]) begin
          b.id = 2'(i);
          b.addr = bus.req_addr[i];
          b.data = bus.req_data[i];
          exp_q.push_back(b);
        end
      end
    end
    $display("step %0d rst_n=%b hold=%b valid=%b lock=%b ready=%b exp=%b",
             step, r, h, v, l, bus.req_ready, exp);
    step++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    beat_t b;
    #1;
    if (bus.wen === 1'b1) begin
      mem[bus.waddr] = bus.wdata;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wen id=%0d addr=%0d data=%h", bus.wgnt_id, bus.waddr, bus.wdata);
      end else begin
        b = exp_q.pop_front();
        if (bus.wgnt_id !== b.id || bus.waddr !== b.addr || bus.wdata !== b.data) begin
          n_fail++;
          $display("FAIL beat got id=%0d addr=%0d data=%h exp id=%0d addr=%0d data=%h",
                   bus.wgnt_id, bus.waddr, bus.wdata, b.id, b.addr, b.data);
        end else begin
          $display("beat id=%0d addr=%0d data=%h", bus.wgnt_id, bus.waddr, bus.wdata);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    bus.req_valid = '0;
    bus.req_lock = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < N_REG; i++) mem[i] = '0;

    // Reset: ready held low even with every request valid.
    cyc(4'hF, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd0, 32'd0);
    chk("rst_wen", 32'(bus.wen), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_wgnt_id", 32'(bus.wgnt_id), 32'd0);

    // Round robin, all valid, no locks.
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 1'b0, 5'd0, 32'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);

    // Locked burst from 1 capped at MAX_BURST, then 2, then 1 re-locks.
    cyc(4'b0110, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'b0110, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'b0110, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'b0110, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'b0110, 4'b0010, 1'b0, 1'b1, 4'b0100, 1'b0, 5'd0, 32'd0);
    cyc(4'b0110, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 5'd0, 32'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);

    // Owner 3 drops valid mid-burst while 0 waits.
    cyc(4'b1001, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0, 5'd0, 32'd0);
    cyc(4'b0001, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 32'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);

    // Hold right after a grant to 2.
    cyc(4'b0100, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 1'b0, 5'd0, 32'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);

    // Reset during the second beat of a burst.
    cyc(4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd0, 32'd0);
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 32'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);

    // Same address from 0 then 2: order must be preserved.
    cyc(4'b0001, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b1, 5'd5, 32'hA);
    cyc(4'b0100, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 5'd5, 32'hB);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'd0);

    chk("regfile_addr5", mem[5], 32'hB);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
